// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the basic-computer control sequencer.
package control_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_INDIRECT = 3'd3,
        ST_EXEC     = 3'd4,
        ST_HALT     = 3'd5
    } state_e;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STA = 3'b011;
    localparam logic [2:0] OP_BUN = 3'b100;
    localparam logic [2:0] OP_BSA = 3'b101;
    localparam logic [2:0] OP_ISZ = 3'b110;
    localparam logic [2:0] OP_REG = 3'b111;

    localparam logic [1:0] ALU_AND  = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_LOAD = 2'b10;
    localparam logic [1:0] ALU_NONE = 2'b11;

    typedef struct packed {
        logic       ld_ar;
        logic       ld_ir;
        logic       ld_dr;
        logic       ld_ac;
        logic       ld_pc;
        logic       inc_pc;
        logic       inc_ar;
        logic       inc_dr;
        logic       mem_rd;
        logic       mem_wr;
        logic       sc_clr;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'({11'b0, ALU_NONE});

    function automatic logic is_one_hot(input logic [15:0] v);
        return (v != 16'h0000) && ((v & (v - 16'd1)) == 16'h0000);
    endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// Pure combinational map from sequencer state, latched opcode and timing pulse
// to control strobes and the next state.
module sequencer_decode
    import control_sequencer_pkg::*;
#(
    parameter int T_LAST = 15
) (
    input  state_e      state,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        ind,
    input  logic [3:0]  ir_hi,
    input  logic        ir_hlt,
    input  logic [15:0] t,
    input  logic        dr_zero,
    output ctrl_t       ctrl,
    output logic        halted,
    output logic        latch_ir,
    output logic        set_timeout,
    output state_e      next_state
);

    logic pulse;

    always_comb begin
        ctrl        = CTRL_NONE;
        halted      = 1'b0;
        latch_ir    = 1'b0;
        set_timeout = 1'b0;
        next_state  = state;
        pulse       = is_one_hot(t);

        case (state)
            ST_IDLE: begin
                if (start) begin
                    ctrl.sc_clr = 1'b1;
                    next_state  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (pulse && t[0]) ctrl.ld_ar = 1'b1;
                if (pulse && t[1]) begin
                    ctrl.mem_rd = 1'b1;
                    ctrl.ld_ir  = 1'b1;
                    ctrl.inc_pc = 1'b1;
                    next_state  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Branch on the live IR; the latched copy is only valid from the next cycle.
                if (pulse && t[2]) begin
                    ctrl.ld_ar = 1'b1;
                    latch_ir   = 1'b1;
                    next_state = (ir_hi[2:0] == OP_REG || !ir_hi[3]) ? ST_EXEC : ST_INDIRECT;
                end
            end
            ST_INDIRECT: begin
                if (pulse && t[3] && ind) begin
                    ctrl.mem_rd = 1'b1;
                    ctrl.ld_ar  = 1'b1;
                    next_state  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (pulse) begin
                    case (op)
                        OP_AND, OP_ADD, OP_LDA: begin
                            if (t[4]) begin
                                ctrl.mem_rd = 1'b1;
                                ctrl.ld_dr  = 1'b1;
                            end
                            if (t[5]) begin
                                ctrl.ld_ac  = 1'b1;
                                ctrl.sc_clr = 1'b1;
                                ctrl.alu_op = (op == OP_AND) ? ALU_AND :
                                              (op == OP_ADD) ? ALU_ADD : ALU_LOAD;
                            end
                        end
                        OP_STA: if (t[4]) begin
                            ctrl.mem_wr = 1'b1;
                            ctrl.sc_clr = 1'b1;
                        end
                        OP_BUN: if (t[4]) begin
                            ctrl.ld_pc  = 1'b1;
                            ctrl.sc_clr = 1'b1;
                        end
                        OP_BSA: begin
                            if (t[4]) begin
                                ctrl.mem_wr = 1'b1;
                                ctrl.inc_ar = 1'b1;
                            end
                            if (t[5]) begin
                                ctrl.ld_pc  = 1'b1;
                                ctrl.sc_clr = 1'b1;
                            end
                        end
                        OP_ISZ: begin
                            if (t[4]) begin
                                ctrl.mem_rd = 1'b1;
                                ctrl.ld_dr  = 1'b1;
                            end
                            if (t[5]) ctrl.inc_dr = 1'b1;
                            if (t[6]) begin
                                ctrl.mem_wr = 1'b1;
                                ctrl.inc_pc = dr_zero;
                                ctrl.sc_clr = 1'b1;
                            end
                        end
                        default: begin
                            if (t[3]) begin
                                if (ir_hlt) next_state  = ST_HALT;
                                else        ctrl.sc_clr = 1'b1;
                            end
                        end
                    endcase
                    if (ctrl.sc_clr) next_state = ST_FETCH;
                end
            end
            ST_HALT: halted = 1'b1;
            default: next_state = ST_IDLE;
        endcase

        // Last pulse reached while an instruction is still in flight.
        if (pulse && t[T_LAST] && !ctrl.sc_clr && next_state != ST_HALT &&
            state inside {ST_FETCH, ST_DECODE, ST_INDIRECT, ST_EXEC}) begin
            next_state  = ST_HALT;
            set_timeout = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Instruction-cycle control sequencer: holds state, latched opcode/I and the
// sticky timeout flag; strobes come from sequencer_decode.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int T_LAST = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] t,
    input  logic        start,
    input  logic [15:0] ir,
    input  logic        dr_zero,
    output logic        ld_ar,
    output logic        ld_ir,
    output logic        ld_dr,
    output logic        ld_ac,
    output logic        ld_pc,
    output logic        inc_pc,
    output logic        inc_ar,
    output logic        inc_dr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        sc_clr,
    output logic        halted,
    output logic        timeout,
    output logic [1:0]  alu_op
);

    state_e     state_q, state_d, next_state;
    logic [2:0] op_q, op_d;
    logic       i_q, i_d;
    logic       timeout_q, timeout_d;
    ctrl_t      ctrl;
    logic       halted_w, latch_ir, set_timeout;
    logic       unused_ir;

    assign unused_ir = ^ir[11:1];

    sequencer_decode #(.T_LAST(T_LAST)) u_decode (
        .state       (state_q),
        .start       (start),
        .op          (op_q),
        .ind         (i_q),
        .ir_hi       (ir[15:12]),
        .ir_hlt      (ir[0]),
        .t           (t),
        .dr_zero     (dr_zero),
        .ctrl        (ctrl),
        .halted      (halted_w),
        .latch_ir    (latch_ir),
        .set_timeout (set_timeout),
        .next_state  (next_state)
    );

    always_comb begin
        state_d   = next_state;
        op_d      = latch_ir ? ir[14:12] : op_q;
        i_d       = latch_ir ? ir[15] : i_q;
        timeout_d = timeout_q | set_timeout;
        if (reset) begin
            state_d   = ST_IDLE;
            op_d      = 3'b000;
            i_d       = 1'b0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        op_q      <= op_d;
        i_q       <= i_d;
        timeout_q <= timeout_d;
    end

    assign ld_ar   = ctrl.ld_ar;
    assign ld_ir   = ctrl.ld_ir;
    assign ld_dr   = ctrl.ld_dr;
    assign ld_ac   = ctrl.ld_ac;
    assign ld_pc   = ctrl.ld_pc;
    assign inc_pc  = ctrl.inc_pc;
    assign inc_ar  = ctrl.inc_ar;
    assign inc_dr  = ctrl.inc_dr;
    assign mem_rd  = ctrl.mem_rd;
    assign mem_wr  = ctrl.mem_wr;
    assign sc_clr  = ctrl.sc_clr;
    assign alu_op  = ctrl.alu_op;
    assign halted  = halted_w;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: directed instruction walks with hand-written expectations,
// then randomized pulses/instructions against a rule-table reference model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, dr_zero = 1'b0;
    logic [15:0] t = 16'h0000, ir = 16'h0000;
    logic        ld_ar, ld_ir, ld_dr, ld_ac, ld_pc, inc_pc, inc_ar, inc_dr;
    logic        mem_rd, mem_wr, sc_clr, halted, timeout;
    logic [1:0]  alu_op;

    control_sequencer #(.T_LAST(15)) dut (
        .clk(clk), .reset(reset), .t(t), .start(start), .ir(ir), .dr_zero(dr_zero),
        .ld_ar(ld_ar), .ld_ir(ld_ir), .ld_dr(ld_dr), .ld_ac(ld_ac), .ld_pc(ld_pc),
        .inc_pc(inc_pc), .inc_ar(inc_ar), .inc_dr(inc_dr), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .sc_clr(sc_clr), .halted(halted), .timeout(timeout),
        .alu_op(alu_op)
    );

    always #5 clk = ~clk;

    // Output word: {ld_ar,ld_ir,ld_dr,ld_ac,ld_pc,inc_pc,inc_ar,inc_dr,mem_rd,mem_wr,sc_clr,halted,timeout,alu_op}
    localparam logic [14:0] LD_AR  = 15'h4000, LD_IR  = 15'h2000, LD_DR  = 15'h1000;
    localparam logic [14:0] LD_AC  = 15'h0800, LD_PC  = 15'h0400, INC_PC = 15'h0200;
    localparam logic [14:0] INC_AR = 15'h0100, INC_DR = 15'h0080, MEM_RD = 15'h0040;
    localparam logic [14:0] MEM_WR = 15'h0020, SC_CLR = 15'h0010, HALTED = 15'h0008;
    localparam logic [14:0] TMO    = 15'h0004, NONE   = 15'h0003;

    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_IND = 3, P_EXEC = 4, P_HALT = 5;

    typedef struct {
        bit          chk;
        logic [14:0] exp;
        int          id;
    } sb_t;

    sb_t         sbq[$];
    int          n_vec = 0, n_bad = 0, n_cyc = 0;
    logic [14:0] r_out [6][8][16];
    int          r_nx  [6][8][16];
    int          ph = P_IDLE, op_l = 0;
    bit          tmo_l = 1'b0;

    function automatic logic [15:0] tp(input int i);
        logic [15:0] one;
        one = 16'h0001;
        return one << i;
    endfunction

    task automatic set_rule(input int p_h, input int op, input int pl, input logic [14:0] o, input int nx);
        r_out[p_h][op][pl] = o;
        r_nx[p_h][op][pl]  = nx;
    endtask

    // Microcode table: (phase, opcode, pulse) -> strobes and phase to enter.
    task automatic build_rules();
        for (int a = 0; a < 6; a++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < 16; c++) set_rule(a, b, c, NONE, -1);
        for (int op = 0; op < 8; op++) begin
            set_rule(P_FETCH,  op, 0, LD_AR | NONE, -1);
            set_rule(P_FETCH,  op, 1, MEM_RD | LD_IR | INC_PC | NONE, P_DECODE);
            set_rule(P_DECODE, op, 2, LD_AR | NONE, -1);
            set_rule(P_IND,    op, 3, MEM_RD | LD_AR | NONE, P_EXEC);
        end
        for (int op = 0; op < 3; op++) begin
            set_rule(P_EXEC, op, 4, MEM_RD | LD_DR | NONE, -1);
            set_rule(P_EXEC, op, 5, LD_AC | SC_CLR | 15'(op), P_FETCH);
        end
        set_rule(P_EXEC, 3, 4, MEM_WR | SC_CLR | NONE, P_FETCH);
        set_rule(P_EXEC, 4, 4, LD_PC | SC_CLR | NONE, P_FETCH);
        set_rule(P_EXEC, 5, 4, MEM_WR | INC_AR | NONE, -1);
        set_rule(P_EXEC, 5, 5, LD_PC | SC_CLR | NONE, P_FETCH);
        set_rule(P_EXEC, 6, 4, MEM_RD | LD_DR | NONE, -1);
        set_rule(P_EXEC, 6, 5, INC_DR | NONE, -1);
        set_rule(P_EXEC, 6, 6, MEM_WR | SC_CLR | NONE, P_FETCH);
    endtask

    task automatic model_step(input bit rst, input bit st, input logic [15:0] tt,
                              input logic [15:0] irr, input bit dz, output logic [14:0] e);
        int nph, nop, p;
        bit ntmo;
        nph = ph; nop = op_l; ntmo = tmo_l; e = NONE; p = 0;
        for (int i = 0; i < 16; i++) if (tt[i]) p = i;
        if (ph == P_IDLE) begin
            if (st) begin e |= SC_CLR; nph = P_FETCH; end
        end else if (ph == P_HALT) begin
            e |= HALTED;
        end else if ($countones(tt) == 1) begin
            e = r_out[ph][op_l][p];
            if (r_nx[ph][op_l][p] >= 0) nph = r_nx[ph][op_l][p];
            if (ph == P_DECODE && p == 2) begin
                nop = int'(irr[14:12]);
                nph = (irr[14:12] == 3'd7 || !irr[15]) ? P_EXEC : P_IND;
            end
            if (ph == P_EXEC && op_l == 7 && p == 3) begin
                if (irr[0]) nph = P_HALT;
                else begin e |= SC_CLR; nph = P_FETCH; end
            end
            if (ph == P_EXEC && op_l == 6 && p == 6 && dz) e |= INC_PC;
            if (p == 15 && (e & SC_CLR) == 15'h0 && nph != P_HALT) begin
                nph = P_HALT; ntmo = 1'b1;
            end
        end
        if (tmo_l) e |= TMO;
        if (rst) begin nph = P_IDLE; nop = 0; ntmo = 1'b0; end
        ph = nph; op_l = nop; tmo_l = ntmo;
    endtask

    task automatic cyc(input bit rst, input bit st, input logic [15:0] tt, input logic [15:0] irr,
                       input bit dz, input bit hand, input logic [14:0] want, output logic [14:0] mexp);
        sb_t it;
        reset = rst; start = st; t = tt; ir = irr; dr_zero = dz;
        model_step(rst, st, tt, irr, dz, mexp);
        it.chk = !rst;
        it.exp = hand ? want : mexp;
        it.id  = n_cyc;
        n_cyc++;
        sbq.push_back(it);
        @(posedge clk); #1;
    endtask

    task automatic dir(input bit rst, input bit st, input logic [15:0] tt, input logic [15:0] irr,
                       input bit dz, input logic [14:0] want);
        logic [14:0] dummy;
        cyc(rst, st, tt, irr, dz, 1'b1, want, dummy);
    endtask

    task automatic fetch_decode(input logic [15:0] irr);
        dir(0, 1'b0, tp(0), irr, 0, LD_AR | NONE);
        dir(0, 1'b0, tp(1), irr, 0, MEM_RD | LD_IR | INC_PC | NONE);
        dir(0, 1'b0, tp(2), irr, 0, LD_AR | NONE);
    endtask

    // Monitor: one response per cycle, compared mid-cycle.
    initial begin
        sb_t         it;
        logic [14:0] got;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                it  = sbq.pop_front();
                got = {ld_ar, ld_ir, ld_dr, ld_ac, ld_pc, inc_pc, inc_ar, inc_dr,
                       mem_rd, mem_wr, sc_clr, halted, timeout, alu_op};
                if (it.chk) begin
                    n_vec++;
                    if (got !== it.exp) begin
                        n_bad++;
                        $display("FAIL ctrl_word cyc=%0d got=%h want=%h", it.id, got, it.exp);
                    end
                end
            end
        end
    end

    initial begin
        logic [14:0] e;
        logic [15:0] tt, irr;
        bit          rst, hold;
        int          sc, r, op, a;

        build_rules();
        @(posedge clk); #1;

        // reset state, ADD direct with an unlisted pulse and an ignored start
        dir(1, 0, tp(0), 16'h0000, 0, NONE);
        dir(0, 0, tp(0), 16'h0000, 0, NONE);
        dir(0, 0, 16'h0000, 16'h0000, 0, NONE);
        dir(0, 1, tp(0), 16'h1005, 0, NONE | SC_CLR);
        dir(0, 0, tp(0), 16'h1005, 0, LD_AR | NONE);
        dir(0, 0, tp(9), 16'h1005, 0, NONE);
        dir(0, 1, tp(1), 16'h1005, 0, MEM_RD | LD_IR | INC_PC | NONE);
        dir(0, 0, tp(2), 16'h1005, 0, LD_AR | NONE);
        dir(0, 0, tp(3), 16'h1005, 0, NONE);
        dir(0, 0, tp(4), 16'h1005, 0, MEM_RD | LD_DR | NONE);
        dir(0, 0, tp(5), 16'h1005, 0, LD_AC | SC_CLR | 15'h0001);
        // AND indirect
        fetch_decode(16'h8005);
        dir(0, 0, tp(3), 16'h8005, 0, MEM_RD | LD_AR | NONE);
        dir(0, 0, tp(4), 16'h8005, 0, MEM_RD | LD_DR | NONE);
        dir(0, 0, tp(5), 16'h8005, 0, LD_AC | SC_CLR);
        // ISZ with dr_zero set, then clear
        for (int z = 1; z >= 0; z--) begin
            fetch_decode(16'h6010);
            dir(0, 0, tp(3), 16'h6010, 0, NONE);
            dir(0, 0, tp(4), 16'h6010, 0, MEM_RD | LD_DR | NONE);
            dir(0, 0, tp(5), 16'h6010, 0, INC_DR | NONE);
            dir(0, 0, tp(6), 16'h6010, 1'(z), MEM_WR | SC_CLR | NONE | (z != 0 ? INC_PC : 15'h0));
        end
        // HLT
        fetch_decode(16'h7001);
        dir(0, 0, tp(3), 16'h7001, 0, NONE);
        dir(0, 0, tp(4), 16'h7001, 0, HALTED | NONE);
        dir(0, 1, tp(0), 16'h7001, 0, HALTED | NONE);
        dir(0, 0, 16'h0000, 16'h7001, 0, HALTED | NONE);
        // two-hot t in FETCH, then timeout
        dir(1, 0, tp(0), 16'h0000, 0, NONE);
        dir(0, 1, tp(0), 16'h0000, 0, NONE | SC_CLR);
        dir(0, 0, 16'h0003, 16'h0000, 0, NONE);
        dir(0, 0, tp(0), 16'h0000, 0, LD_AR | NONE);
        dir(0, 0, tp(15), 16'h0000, 0, NONE);
        dir(0, 0, tp(0), 16'h0000, 0, HALTED | TMO | NONE);
        dir(0, 1, tp(1), 16'h0000, 0, HALTED | TMO | NONE);
        // reset during STA write pulse
        dir(1, 0, tp(0), 16'h0000, 0, NONE);
        dir(0, 1, tp(0), 16'h3000, 0, NONE | SC_CLR);
        fetch_decode(16'h3000);
        dir(0, 0, tp(3), 16'h3000, 0, NONE);
        dir(1, 0, tp(4), 16'h3000, 0, NONE);
        dir(0, 0, tp(5), 16'h3000, 0, NONE);
        dir(0, 0, tp(6), 16'h3000, 0, NONE);

        // randomized run: pulse counter follows the model's sc_clr
        cyc(1, 0, tp(0), 16'h0000, 0, 1'b0, NONE, e);
        sc = 0;
        for (int k = 0; k < 3000; k++) begin
            rst  = (ph == P_HALT) ? ($urandom_range(3) == 0) : ($urandom_range(199) == 0);
            r    = $urandom_range(31);
            hold = 1'b0;
            if (r == 0) begin
                tt = 16'h0000; hold = 1'b1;
            end else if (r == 1) begin
                a  = $urandom_range(15);
                tt = tp(a) | tp((a + 1 + $urandom_range(14)) % 16);
                hold = 1'b1;
            end else if (r == 2) begin
                tt = tp($urandom_range(15));
            end else begin
                tt = tp(sc);
            end
            op  = $urandom_range(7);
            irr = 16'($urandom);
            irr[14:12] = 3'(op);
            if (op == 7) irr[0] = ($urandom_range(3) == 0);
            cyc(rst, 1'($urandom_range(1)), tt, irr, 1'($urandom_range(1)), 1'b0, NONE, e);
            if (rst || (e & SC_CLR) != 15'h0) sc = 0;
            else if (!hold) sc = (sc + 1) % 16;
        end

        for (int w = 0; w < 20 && sbq.size() != 0; w++) @(posedge clk);
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d want=0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
